// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared definitions for the bit-serial adder/subtractor.
//               - FSM state encoding (IDLE / RUN / DONE)
//               - Legal range bounds for the WIDTH parameter
// Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    // Legal operand width range
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_fa_cell
// Description : Combinational one-bit full adder. The bit-serial datapath
//               pushes every operand bit through this single cell.
// Ports       : a_i, b_i, cin_i -> sum_o, cout_o
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_fa_cell (
    input  logic a_i,     // operand A bit
    input  logic b_i,     // operand B bit (already inverted for subtraction)
    input  logic cin_i,   // carry in
    output logic sum_o,   // sum bit
    output logic cout_o   // carry out
);

    logic w_axb;

    assign w_axb  = a_i ^ b_i;
    assign sum_o  = w_axb ^ cin_i;
    assign cout_o = (a_i & b_i) | (w_axb & cin_i);

endmodule : serial_addsub_fa_cell
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Parametrised bit-serial adder/subtractor. Operands are
//               latched on an accepted start, then processed LSB first, one
//               bit per clock, through a single full-adder cell. The result,
//               final carry and signed overflow are loaded together on the
//               last bit, so they never expose partial sums.
//
//               Subtraction is a + ~b + 1: B is inverted at load time and the
//               carry flop is preset to 1. carry_out=1 therefore means
//               "no borrow" for a subtraction.
//
// Optional    : SERIAL_ADDSUB_SAT_EN - when defined, an overflowing result is
//               clamped to the most positive / most negative WIDTH-bit value
//               (direction taken from operand A's sign). carry_out and
//               overflow always report the raw values.
//
// Parameters  : WIDTH  - operand/result width, 2..32 (default 8)
//               CNT_W  - bit-index counter width, derived; do not override
//
// Ports       : clk        in   clock, rising edge
//               rst        in   asynchronous active-high reset
//               start      in   operation request, sampled when busy=0
//               sub        in   0: a+b, 1: a-b (sampled with start)
//               a, b       in   WIDTH-bit operands (sampled with start)
//               result     out  last completed sum/difference
//               carry_out  out  final carry of last operation
//               overflow   out  two's-complement overflow of last operation
//               busy       out  high while bits are being processed
//               done       out  one-cycle completion pulse
//
// Timing      : start accepted at edge k -> done=1 / outputs valid after
//               edge k+WIDTH. start held through DONE starts the next
//               operation immediately (one operation every WIDTH+1 cycles).
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_bad
            $error("serial_addsub: WIDTH out of legal range");
        end
        if (CNT_W != $clog2(WIDTH)) begin : g_cntw_bad
            $error("serial_addsub: CNT_W is derived from WIDTH and must not be overridden");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;        // operand A, shifted right each bit
    logic [WIDTH-1:0]   b_sh_q;        // operand B (pre-inverted for sub)
    // Partial sum. Only WIDTH-1 bits are stored: the last sum bit goes
    // straight from the cell into the result register.
    logic [WIDTH-2:0]   sum_sh_q;
    logic               carry_q;       // running carry between bit slices
    logic [CNT_W-1:0]   cnt_q;         // index of the bit being processed

    logic [WIDTH-1:0]   result_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic               busy_q;
    logic               done_q;

    // ------------------------------------------------------------------------
    // Single full-adder cell
    // ------------------------------------------------------------------------
    logic w_fa_sum;
    logic w_fa_cout;

    serial_addsub_fa_cell u_fa_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (w_fa_sum),
        .cout_o (w_fa_cout)
    );

    // ------------------------------------------------------------------------
    // Next-state datapath values
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] sum_full_d;   // sum register after this bit shifts in
    logic             last_bit_d;   // this edge processes the MSB
    logic             overflow_d;   // valid only when last_bit_d
    logic [WIDTH-1:0] result_d;

    assign sum_full_d = {w_fa_sum, sum_sh_q};
    assign last_bit_d = (cnt_q == c_LAST_BIT);
    // On the MSB slice carry_q is the carry into the MSB and the cell's
    // carry is the carry out of it.
    assign overflow_d = carry_q ^ w_fa_cout;

`ifdef SERIAL_ADDSUB_SAT_EN
    // On the MSB slice a_sh_q[0] is operand A's sign bit. Overflow can only
    // occur when the effective operands share a sign, so A's sign gives the
    // overflow direction for both add and subtract.
    assign result_d = !overflow_d ? sum_full_d :
                      (a_sh_q[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign result_d = sum_full_d;
`endif

    // ------------------------------------------------------------------------
    // Controller + datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE accept a new request identically; DONE
                // additionally drops the done pulse after one cycle.
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        carry_q <= sub;          // +1 of the two's complement
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= sum_full_d[WIDTH-1:1];
                    carry_q  <= w_fa_cout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_bit_d) begin
                        result_q    <= result_d;
                        carry_out_q <= w_fa_cout;
                        overflow_q  <= overflow_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (WIDTH=8). Stimulus
//               pushes the expected completion into a queue; an independent
//               monitor pops and compares on every done pulse. Random
//               operations are predicted by an integer-arithmetic model.
//               Honours SERIAL_ADDSUB_SAT_EN for saturated expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    logic [W-1:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic o);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.o   = o;
        return e;
    endfunction

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        exp_t   e;
        longint ua, ub, full, sa, sb, tv;
        longint modv, maxs, mins;
        modv = longint'(1) << W;
        maxs = (longint'(1) << (W - 1)) - 1;
        mins = -(longint'(1) << (W - 1));
        ua   = longint'(av);
        ub   = longint'(bv);
        full = s ? (ua + (modv - 1 - ub) + 1) : (ua + ub);
        e.c   = (full >= modv);
        e.res = W'(full % modv);
        sa = av[W-1] ? ua - modv : ua;
        sb = bv[W-1] ? ub - modv : ub;
        tv = s ? (sa - sb) : (sa + sb);
        e.o = (tv > maxs) || (tv < mins);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (e.o) e.res = (tv > 0) ? W'(maxs) : W'(mins);
`endif
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 with result %0h, expected no completion", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("carry_out", 32'(carry_out), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.o));
            end
            last_res = result;
        end else begin
            chk("result_hold", 32'(result), 32'(last_res));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
        end
    endtask

    // One operation; checks latency and busy duration. mid_start fires a
    // start pulse with other operands while the operation is running.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         input exp_t e, input bit mid_start);
        int j;
        int bc;
        wait_idle();
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = s;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        bc = 0;
        for (j = 0; j <= 4 * W; j++) begin
            @(negedge clk);
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom_range(0, 1));
            start = (mid_start && j == 2);
            if (done === 1'b1) break;
            if (busy === 1'b1) bc++;
        end
        start = 1'b0;
        chk("latency", 32'(j), 32'(W));
        chk("busy_cycles", 32'(bc), 32'(W));
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int   dc;
        int   j1;
        int   j2;
        exp_t e;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 0);
        chk("rst_carry", 32'(carry_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); #3 rst = 1'b0;

        // Signed overflow (gives a nonzero result before the abort test)
`ifdef SERIAL_ADDSUB_SAT_EN
        do_op(8'h7F, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1), 1'b0);
`else
        do_op(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1), 1'b0);
`endif

        // Reset mid-RUN aborts: outputs cleared at once, no done pulse
        wait_idle();
        start = 1'b1; a = 8'h55; b = 8'h22; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_result", 32'(result), 0);
        chk("abort_carry", 32'(carry_out), 0);
        chk("abort_ovf", 32'(overflow), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        @(negedge clk); @(posedge clk); #3 rst = 1'b0;
        dc = done_cnt;
        repeat (2 * W) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        do_op(8'h01, 8'h01, 1'b0, mk(8'h02, 1'b0, 1'b0), 1'b0);

        // Directed corners
        do_op(8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), 1'b0);
        do_op(8'h05, 8'h07, 1'b1, mk(8'hFE, 1'b0, 1'b0), 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
        do_op(8'h80, 8'h01, 1'b1, mk(8'h80, 1'b1, 1'b1), 1'b0);
`else
        do_op(8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b1, 1'b1), 1'b0);
`endif
        // start while busy must be ignored
        do_op(8'h3C, 8'h0F, 1'b0, mk(8'h4B, 1'b0, 1'b0), 1'b1);

        // Back-to-back: start held high through DONE
        wait_idle();
        start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
        @(posedge clk);
        exp_q.push_back(mk(8'h46, 1'b0, 1'b0));
        #1;
        a = 8'h90; b = 8'h20; sub = 1'b1;
        for (j1 = 0; j1 <= 4 * W; j1++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("b2b_first_latency", 32'(j1), 32'(W));
        @(posedge clk);
`ifdef SERIAL_ADDSUB_SAT_EN
        exp_q.push_back(mk(8'h80, 1'b1, 1'b1));
`else
        exp_q.push_back(mk(8'h70, 1'b1, 1'b1));
`endif
        #1 start = 1'b0;
        for (j2 = 0; j2 <= 4 * W; j2++) begin
            @(negedge clk);
            if (j2 == 0) chk("b2b_busy_after_done", 32'(busy), 1);
            if (done === 1'b1) break;
        end
        chk("b2b_done_spacing", 32'(j2 + 1), 32'(W + 1));

        // Randomised operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            do_op(ra, rb, rs, e, bit'($urandom_range(0, 3) == 0));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_addsub
`default_nettype wire
